ecc_apb_regfile: RTL and testbench

//  APB slave register bank directly upstream of the ECC encoder/decoder core.

---
 rtl/ecc_apb_regfile.sv | 150 +++++++++++++++
 tb/tb_ecc_apb_regfile.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_apb_regfile.sv
// APB register bank that configures the ECC core, fires a one-cycle start pulse,
// and captures data_out / num_of_errors when the core signals completion.
module ecc_apb_regfile #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
  input  logic [AMBA_WORD-1:0]       pwdata,
  output logic [AMBA_WORD-1:0]       prdata,
  output logic                       start,
  output logic [1:0]                 ctrl,
  output logic [DATA_WIDTH-1:0]      data_in,
  output logic [1:0]                 codeword_width,
  output logic [DATA_WIDTH-1:0]      noise,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      core_data_out,
  input  logic [1:0]                 core_num_errors
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_DATA   = 3'd1;
  localparam logic [2:0] A_CW     = 3'd2;
  localparam logic [2:0] A_NOISE  = 3'd3;
  localparam logic [2:0] A_RESULT = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BUSY = 2'd2} state_t;

  typedef struct packed {
    logic [1:0]            ctrl;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            cw;
    logic [DATA_WIDTH-1:0] noise;
  } cfg_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            errs;
  } res_t;

  state_t state, state_nxt;
  cfg_t   cfg_q;
  res_t   res_q;
  logic   done_q, ovr_q;

  logic [2:0]           addr;
  logic                 wr_acc, rd_setup, rd_acc;
  logic                 cfg_wr, cfg_commit, ovr_set, go;
  logic                 busy, capture, stat_clr;
  logic [AMBA_WORD-1:0] rd_mux;
  logic                 unused_bits;

  assign addr     = paddr[4:2];
  assign wr_acc   = psel & penable & pwrite;
  assign rd_setup = psel & ~penable & ~pwrite;
  assign rd_acc   = psel & penable & ~pwrite;

  // Only the low four addresses are writable; everything else is dropped.
  assign cfg_wr     = wr_acc & ~addr[2];
  assign busy       = (state != IDLE);
  assign cfg_commit = cfg_wr & ~busy;
  assign ovr_set    = cfg_wr & busy;
  assign go         = cfg_commit & (addr == A_CTRL) & (pwdata[1:0] != 2'd3);
  assign capture    = (state == BUSY) & operation_done;
  assign stat_clr   = rd_acc & (addr == A_STATUS);

  // Upper address/data bits are architecturally ignored.
  assign unused_bits = ^{paddr, pwdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = START;
      START:   state_nxt = BUSY;
      BUSY:    if (operation_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start = (state == START);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q <= '0;
    end else if (cfg_commit) begin
      case (addr)
        A_CTRL:  cfg_q.ctrl  <= pwdata[1:0];
        A_DATA:  cfg_q.data  <= pwdata[DATA_WIDTH-1:0];
        A_CW:    cfg_q.cw    <= pwdata[1:0];
        A_NOISE: cfg_q.noise <= pwdata[DATA_WIDTH-1:0];
        default: cfg_q <= cfg_q;
      endcase
    end
  end

  assign ctrl           = cfg_q.ctrl;
  assign data_in        = cfg_q.data;
  assign codeword_width = cfg_q.cw;
  assign noise          = cfg_q.noise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         res_q <= '0;
    else if (capture) res_q <= '{data: core_data_out, errs: core_num_errors};
  end

  // A completion landing on the STATUS read edge keeps done set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (capture)       done_q <= 1'b1;
      else if (stat_clr) done_q <= 1'b0;
      if (ovr_set)       ovr_q  <= 1'b1;
      else if (stat_clr) ovr_q  <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_CTRL:   rd_mux = AMBA_WORD'(cfg_q.ctrl);
      A_DATA:   rd_mux = AMBA_WORD'(cfg_q.data);
      A_CW:     rd_mux = AMBA_WORD'(cfg_q.cw);
      A_NOISE:  rd_mux = AMBA_WORD'(cfg_q.noise);
      A_RESULT: rd_mux = AMBA_WORD'(res_q.data);
      A_STATUS: rd_mux = AMBA_WORD'({done_q, ovr_q, res_q.errs, busy});
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          prdata <= '0;
    else if (rd_setup) prdata <= rd_mux;
  end

endmodule

// File: tb/tb_ecc_apb_regfile.sv
// Randomized self-checking bench for ecc_apb_regfile against a register-level model.
module tb_ecc_apb_regfile;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int ADW = 32;

  localparam logic [ADW-1:0] R_CTRL   = 32'h00;
  localparam logic [ADW-1:0] R_DATA   = 32'h04;
  localparam logic [ADW-1:0] R_CW     = 32'h08;
  localparam logic [ADW-1:0] R_NOISE  = 32'h0C;
  localparam logic [ADW-1:0] R_RESULT = 32'h10;
  localparam logic [ADW-1:0] R_STATUS = 32'h14;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [ADW-1:0] paddr = '0;
  logic [AW-1:0]  pwdata = '0;
  logic [AW-1:0]  prdata;
  logic           start;
  logic [1:0]     ctrl;
  logic [DW-1:0]  data_in;
  logic [1:0]     codeword_width;
  logic [DW-1:0]  noise;
  logic           operation_done = 1'b0;
  logic [DW-1:0]  core_data_out = '0;
  logic [1:0]     core_num_errors = '0;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;

  // Register-level model of the bank
  logic [1:0]    m_ctrl, m_cw, m_errs;
  logic [DW-1:0] m_data, m_noise, m_result;
  logic          m_busy, m_ovr, m_done;

  ecc_apb_regfile #(.DATA_WIDTH(DW), .AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .start(start), .ctrl(ctrl),
    .data_in(data_in), .codeword_width(codeword_width), .noise(noise),
    .operation_done(operation_done), .core_data_out(core_data_out),
    .core_num_errors(core_num_errors)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start === 1'b1) start_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_ctrl = 0; m_cw = 0; m_errs = 0; m_data = 0; m_noise = 0; m_result = 0;
    m_busy = 0; m_ovr = 0; m_done = 0;
  endtask

  function automatic logic [AW-1:0] model_read(input logic [ADW-1:0] a);
    case (a[4:2])
      3'd0:    return AW'(m_ctrl);
      3'd1:    return AW'(m_data);
      3'd2:    return AW'(m_cw);
      3'd3:    return AW'(m_noise);
      3'd4:    return AW'(m_result);
      3'd5:    return AW'({m_done, m_ovr, m_errs, m_busy});
      default: return '0;
    endcase
  endfunction

  task automatic apb_write(input logic [ADW-1:0] a, input logic [AW-1:0] d);
    @(negedge clk); psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(negedge clk); penable = 1;
    @(negedge clk); psel = 0; penable = 0; pwrite = 0;
    if (a[4:2] <= 3'd3) begin
      if (m_busy) m_ovr = 1;
      else begin
        case (a[4:2])
          3'd0: begin m_ctrl = d[1:0]; if (d[1:0] != 2'd3) m_busy = 1; end
          3'd1: m_data  = d[DW-1:0];
          3'd2: m_cw    = d[1:0];
          default: m_noise = d[DW-1:0];
        endcase
      end
    end
  endtask

  task automatic apb_read(input logic [ADW-1:0] a, output logic [AW-1:0] d);
    @(negedge clk); psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(negedge clk); penable = 1;
    @(negedge clk); psel = 0; penable = 0;
    d = prdata;
    if (a[4:2] == 3'd5) begin m_ovr = 0; m_done = 0; end
  endtask

  task automatic core_done(input logic [DW-1:0] d, input logic [1:0] e);
    @(negedge clk); operation_done = 1; core_data_out = d; core_num_errors = e;
    @(negedge clk); operation_done = 0;
    if (m_busy) begin m_result = d; m_errs = e; m_done = 1; m_busy = 0; end
  endtask

  task automatic test_reset();
    logic [AW-1:0] got, exp;
    model_reset();
    #1;
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL rst_start got=%h exp=0", start); end
    checks++; if (ctrl !== 2'd0 || data_in !== '0 || noise !== '0 || codeword_width !== 2'd0) begin
      failures++; $display("FAIL rst_cfg got=%h/%h/%h/%h exp=0", ctrl, data_in, codeword_width, noise); end
    checks++; if (prdata !== '0) begin failures++; $display("FAIL rst_prdata got=%h exp=0", prdata); end
    repeat (3) @(negedge clk);
    rst = 1;
    exp = 32'h0; apb_read(R_STATUS, got);
    checks++; if (got !== exp) begin failures++; $display("FAIL rst_status got=%h exp=%h", got, exp); end
  endtask

  task automatic test_basic_op();
    logic [AW-1:0] got;
    int s0;
    apb_write(R_DATA, 32'h0000_00A5);
    apb_write(R_CW, 32'h1);
    apb_write(R_NOISE, 32'h0);
    s0 = start_cnt;
    apb_write(R_CTRL, 32'h0);
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL basic_start_latency got=%h exp=1", start); end
    checks++; if (data_in !== 32'hA5 || codeword_width !== 2'd1) begin
      failures++; $display("FAIL basic_cfg got=%h/%h exp=a5/1", data_in, codeword_width); end
    apb_read(R_STATUS, got);
    checks++; if (got !== 32'h1) begin failures++; $display("FAIL basic_busy got=%h exp=1", got); end
    core_done(32'h1234, 2'd0);
    repeat (3) @(negedge clk);
    checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL basic_pulse_count got=%0d exp=1", start_cnt - s0); end
    apb_read(R_RESULT, got);
    checks++; if (got !== 32'h1234) begin failures++; $display("FAIL basic_result got=%h exp=1234", got); end
    apb_read(R_STATUS, got);
    checks++; if (got !== 32'h10) begin failures++; $display("FAIL basic_status got=%h exp=10", got); end
  endtask

  task automatic test_ovr();
    logic [AW-1:0] got, exp;
    logic [DW-1:0] n0;
    n0 = m_noise;
    apb_write(R_CTRL, 32'h2);
    apb_write(R_NOISE, 32'hFFFF_FFFF);
    checks++; if (noise !== n0) begin failures++; $display("FAIL ovr_noise_stable got=%h exp=%h", noise, n0); end
    checks++; if (ctrl !== 2'd2) begin failures++; $display("FAIL ovr_ctrl_stable got=%h exp=2", ctrl); end
    exp = model_read(R_STATUS); apb_read(R_STATUS, got);
    checks++; if (got !== exp || got[3] !== 1'b1) begin failures++; $display("FAIL ovr_set got=%h exp=%h", got, exp); end
    exp = model_read(R_STATUS); apb_read(R_STATUS, got);
    checks++; if (got !== exp || got[3] !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%h exp=%h", got, exp); end
    core_done(32'hCAFE_0001, 2'd2);
    exp = model_read(R_STATUS); apb_read(R_STATUS, got);
    checks++; if (got !== exp) begin failures++; $display("FAIL ovr_done_status got=%h exp=%h", got, exp); end
  endtask

  task automatic test_ctrl3();
    logic [AW-1:0] got, exp;
    int s0;
    s0 = start_cnt;
    apb_write(R_CTRL, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    checks++; if (ctrl !== 2'd3) begin failures++; $display("FAIL ctrl3_value got=%h exp=3", ctrl); end
    checks++; if (start_cnt !== s0) begin failures++; $display("FAIL ctrl3_no_start got=%0d exp=%0d", start_cnt, s0); end
    exp = model_read(R_STATUS); apb_read(R_STATUS, got);
    checks++; if (got !== exp || got[0] !== 1'b0) begin failures++; $display("FAIL ctrl3_idle got=%h exp=%h", got, exp); end
  endtask

  task automatic test_done_ignored_start();
    logic [AW-1:0] got, exp;
    logic [DW-1:0] r0;
    r0 = m_result;
    core_done(32'hDEAD_BEEF, 2'd3);
    apb_write(R_CTRL, 32'h1);
    operation_done = 1; core_data_out = 32'h5555_AAAA; core_num_errors = 2'd1;
    @(negedge clk); operation_done = 0;
    exp = model_read(R_STATUS); apb_read(R_STATUS, got);
    checks++; if (got !== exp) begin failures++; $display("FAIL start_done_ignored got=%h exp=%h", got, exp); end
    apb_read(R_RESULT, got);
    checks++; if (got !== AW'(r0)) begin failures++; $display("FAIL idle_done_ignored got=%h exp=%h", got, r0); end
    core_done(32'h0BAD_F00D, 2'd1);
  endtask

  task automatic test_done_clear_race();
    logic [AW-1:0] got, exp;
    logic [DW-1:0] r;
    r = $urandom;
    apb_write(R_CTRL, 32'h0);
    @(negedge clk); psel = 1; penable = 0; pwrite = 0; paddr = R_STATUS;
    exp = model_read(R_STATUS);
    @(negedge clk); penable = 1; operation_done = 1; core_data_out = r; core_num_errors = 2'd2;
    @(negedge clk); psel = 0; penable = 0; operation_done = 0;
    got = prdata;
    checks++; if (got !== exp) begin failures++; $display("FAIL race_read got=%h exp=%h", got, exp); end
    m_ovr = 0; m_result = r; m_errs = 2'd2; m_done = 1; m_busy = 0;
    exp = model_read(R_STATUS); apb_read(R_STATUS, got);
    checks++; if (got !== exp || got[4] !== 1'b1) begin failures++; $display("FAIL race_done_wins got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] got, exp;
    apb_write(R_CTRL, 32'h1);
    #2 rst = 0;
    #1;
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL rstmid_start got=%h exp=0", start); end
    model_reset();
    @(negedge clk); rst = 1;
    apb_write(R_CTRL, 32'h2);
    @(negedge clk); #2 rst = 0; #1;
    checks++; if (start !== 1'b0 || ctrl !== 2'd0) begin failures++; $display("FAIL rstmid_busy got=%h/%h exp=0/0", start, ctrl); end
    model_reset();
    @(negedge clk); rst = 1;
    exp = model_read(R_STATUS); apb_read(R_STATUS, got);
    checks++; if (got !== exp) begin failures++; $display("FAIL rstmid_status got=%h exp=%h", got, exp); end
    core_done(32'h7777_1111, 2'd3);
    apb_read(R_RESULT, got);
    checks++; if (got !== 32'h0) begin failures++; $display("FAIL rstmid_stray_done got=%h exp=0", got); end
  endtask

  task automatic test_unmapped();
    logic [AW-1:0] got, exp;
    core_done(32'h1, 2'd1);
    apb_write(R_CTRL, 32'h0);
    core_done($urandom, 2'($urandom_range(0, 3)));
    apb_read(32'h18, got);
    checks++; if (got !== 32'h0) begin failures++; $display("FAIL unmapped_18 got=%h exp=0", got); end
    apb_write(32'h1C, $urandom);
    apb_read(32'h1C, got);
    checks++; if (got !== 32'h0) begin failures++; $display("FAIL unmapped_1c got=%h exp=0", got); end
    apb_write(R_RESULT, 32'hFFFF_0000);
    apb_write(R_STATUS, 32'hFFFF_FFFF);
    exp = model_read(R_RESULT); apb_read(R_RESULT, got);
    checks++; if (got !== exp) begin failures++; $display("FAIL ro_result got=%h exp=%h", got, exp); end
    exp = model_read(R_STATUS); apb_read(R_STATUS, got);
    checks++; if (got !== exp) begin failures++; $display("FAIL ro_status got=%h exp=%h", got, exp); end
  endtask

  task automatic test_random();
    logic [AW-1:0] got, exp, w;
    logic [ADW-1:0] a;
    int s0;
    for (int i = 0; i < 24; i++) begin
      apb_write(R_DATA, $urandom);
      apb_write(R_CW, $urandom);
      apb_write(R_NOISE, $urandom);
      w = $urandom; w[1:0] = 2'($urandom_range(0, 3));
      s0 = start_cnt;
      apb_write(R_CTRL, w);
      checks++; if (start !== (w[1:0] != 2'd3)) begin failures++; $display("FAIL rnd_start[%0d] got=%h exp=%h", i, start, w[1:0] != 2'd3); end
      if (m_busy) begin
        if ($urandom_range(0, 1) == 1) apb_write(ADW'($urandom_range(0, 3) * 4), $urandom);
        exp = model_read(R_STATUS); apb_read(R_STATUS, got);
        checks++; if (got !== exp) begin failures++; $display("FAIL rnd_busy_status[%0d] got=%h exp=%h", i, got, exp); end
        checks++; if (ctrl !== m_ctrl || data_in !== m_data || codeword_width !== m_cw || noise !== m_noise) begin
          failures++; $display("FAIL rnd_outputs[%0d] got=%h/%h/%h/%h exp=%h/%h/%h/%h", i,
            ctrl, data_in, codeword_width, noise, m_ctrl, m_data, m_cw, m_noise); end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        core_done($urandom, 2'($urandom_range(0, 3)));
        checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL rnd_pulse[%0d] got=%0d exp=1", i, start_cnt - s0); end
      end
      a = ADW'($urandom_range(0, 7) * 4);
      exp = model_read(a); apb_read(a, got);
      checks++; if (got !== exp) begin failures++; $display("FAIL rnd_read[%0d] addr=%h got=%h exp=%h", i, a, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_op();
    test_ovr();
    test_ctrl3();
    test_done_ignored_start();
    test_done_clear_race();
    test_reset_mid();
    test_unmapped();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
